// File: rtl/segre_store_buffer_n_pkg.sv
// segre_store_buffer_n_pkg: shared types, sizes and lane helpers for the N-entry store buffer
package segre_store_buffer_n_pkg;
   localparam int SB_NUM_ENTRIES = 4;
   localparam int SB_ADDR_SIZE = 32;
   localparam int SB_WORD_SIZE = 32;
   typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
   typedef enum logic [1:0] {SB_HIT, SB_MISS, SB_TROUBLE} sb_lookup_e;
   typedef struct packed {
      logic [SB_ADDR_SIZE-3:0] word_addr;
      logic [SB_WORD_SIZE-1:0] data;
      logic [SB_WORD_SIZE/8-1:0] be;
   } sb_entry_t;
   function automatic logic [3:0] memop_be(input memop_data_type_e t, input logic [1:0] off);
      return t == BYTE ? 4'b0001 << off : t == HALF ? 4'b0011 << off : 4'b1111;
   endfunction
   function automatic logic [4:0] memop_shift(input logic [1:0] off);
      return {off, 3'b000};
   endfunction
endpackage

// File: rtl/segre_store_buffer_n_if.sv
// segre_store_buffer_n_if: store, load-lookup and drain ports of the store buffer
interface segre_store_buffer_n_if
   import segre_store_buffer_n_pkg::*;
#(
   parameter int ADDR_SIZE = SB_ADDR_SIZE,
   parameter int WORD_SIZE = SB_WORD_SIZE,
   parameter int NUM_ENTRIES = SB_NUM_ENTRIES
);
   logic store_valid_i, store_ready_o;
   logic [ADDR_SIZE-1:0] store_addr_i;
   logic [WORD_SIZE-1:0] store_data_i;
   memop_data_type_e store_type_i;
   logic load_req_i;
   logic [ADDR_SIZE-1:0] load_addr_i;
   memop_data_type_e load_type_i;
   logic load_hit_o, load_miss_o, load_trouble_o;
   logic [WORD_SIZE-1:0] load_data_o;
   logic flush_valid_o, flush_ready_i;
   logic [ADDR_SIZE-1:0] flush_addr_o;
   logic [WORD_SIZE-1:0] flush_data_o;
   logic [WORD_SIZE/8-1:0] flush_be_o;
   logic [$clog2(NUM_ENTRIES):0] count_o;
   logic full_o, empty_o;
   modport master (
      output store_valid_i, store_addr_i, store_data_i, store_type_i,
      output load_req_i, load_addr_i, load_type_i, flush_ready_i,
      input store_ready_o, load_hit_o, load_miss_o, load_trouble_o, load_data_o,
      input flush_valid_o, flush_addr_o, flush_data_o, flush_be_o, count_o, full_o, empty_o
   );
   modport slave (
      input store_valid_i, store_addr_i, store_data_i, store_type_i,
      input load_req_i, load_addr_i, load_type_i, flush_ready_i,
      output store_ready_o, load_hit_o, load_miss_o, load_trouble_o, load_data_o,
      output flush_valid_o, flush_addr_o, flush_data_o, flush_be_o, count_o, full_o, empty_o
   );
endinterface

// File: rtl/segre_store_buffer_n_sb_forward.sv
// segre_sb_forward: per byte lane, picks the youngest valid entry matching the load word
module segre_sb_forward #(
   parameter int N = 4,
   parameter int AW = 30,
   parameter int WS = 32
) (
   input logic [N-1:0] valid,
   input logic [N-1:0][AW-1:0] waddr,
   input logic [N-1:0][WS-1:0] data,
   input logic [N-1:0][WS/8-1:0] be,
   input logic [$clog2(N)-1:0] head,
   input logic [AW-1:0] ld_waddr,
   output logic [WS-1:0] fwd_data,
   output logic [WS/8-1:0] covered
);
   logic [$clog2(N)-1:0] idx;
   // walking oldest to youngest lets later (younger) entries overwrite each lane
   always_comb begin
      fwd_data = '0;
      covered = '0;
      idx = head;
      for (int k = 0; k < N; k++) begin
         idx = head + $clog2(N)'(k);
         for (int b = 0; b < WS/8; b++)
            if (valid[idx] && waddr[idx] == ld_waddr && be[idx][b]) begin
               covered[b] = 1'b1;
               fwd_data[8*b +: 8] = data[idx][8*b +: 8];
            end
      end
   end
endmodule

// File: rtl/segre_store_buffer_n.sv
// segre_store_buffer_n: N-entry circular store buffer with coalescing, byte forwarding and in-order drain
module segre_store_buffer_n
   import segre_store_buffer_n_pkg::*;
#(
   parameter int NUM_ENTRIES = SB_NUM_ENTRIES,
   parameter int ADDR_SIZE = SB_ADDR_SIZE,
   parameter int WORD_SIZE = SB_WORD_SIZE,
   parameter bit COALESCE_EN = 1'b1
) (
   input logic clk_i,
   input logic rst_i,
   segre_store_buffer_n_if.slave sb
);
   localparam int L = WORD_SIZE/8;
   localparam int PW = $clog2(NUM_ENTRIES);
   localparam int AW = ADDR_SIZE-2;
   localparam logic [PW:0] CAP = (PW+1)'(NUM_ENTRIES);
   logic [NUM_ENTRIES-1:0] valid;
   logic [NUM_ENTRIES-1:0][AW-1:0] waddr;
   logic [NUM_ENTRIES-1:0][WORD_SIZE-1:0] data;
   logic [NUM_ENTRIES-1:0][L-1:0] be;
   logic [PW-1:0] head, tail, young;
   logic [PW:0] count;
   logic [L-1:0] st_be, ld_rm, ld_cov, fwd_cov;
   logic [WORD_SIZE-1:0] st_data, st_bm, ld_bm, fwd_data;
   logic coal_match, coalesce, push, pop, fv;
   sb_lookup_e lookup;
   always_comb begin
      young = tail - 1'b1;
      st_be = sb.store_type_i == WORD ? '1 : L'(memop_be(sb.store_type_i, sb.store_addr_i[1:0]));
      ld_rm = sb.load_type_i == WORD ? '1 : L'(memop_be(sb.load_type_i, sb.load_addr_i[1:0]));
      st_data = sb.store_data_i << memop_shift(sb.store_addr_i[1:0]);
      ld_cov = fwd_cov & ld_rm;
      st_bm = '0;
      ld_bm = '0;
      for (int b = 0; b < L; b++) begin
         st_bm[8*b +: 8] = {8{st_be[b]}};
         ld_bm[8*b +: 8] = {8{ld_cov[b]}};
      end
      fv = count != '0;
      pop = fv && sb.flush_ready_i;
      coal_match = COALESCE_EN && fv && waddr[young] == sb.store_addr_i[ADDR_SIZE-1:2];
      // a head entry leaving this cycle cannot absorb the store, so it allocates instead
      coalesce = coal_match && !(young == head && pop);
      push = sb.store_valid_i && sb.store_ready_o && !coalesce;
      lookup = ld_cov == ld_rm ? SB_HIT : ld_cov == '0 ? SB_MISS : SB_TROUBLE;
   end
   segre_sb_forward #(.N(NUM_ENTRIES), .AW(AW), .WS(WORD_SIZE)) u_forward (
      .valid(valid),
      .waddr(waddr),
      .data(data),
      .be(be),
      .head(head),
      .ld_waddr(sb.load_addr_i[ADDR_SIZE-1:2]),
      .fwd_data(fwd_data),
      .covered(fwd_cov)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (pop) begin
            valid[head] <= 1'b0;
            head <= head + 1'b1;
         end
         if (push) begin
            valid[tail] <= 1'b1;
            waddr[tail] <= sb.store_addr_i[ADDR_SIZE-1:2];
            data[tail] <= st_data & st_bm;
            be[tail] <= st_be;
            tail <= tail + 1'b1;
         end else if (sb.store_valid_i && coalesce) begin
            data[young] <= (data[young] & ~st_bm) | (st_data & st_bm);
            be[young] <= be[young] | st_be;
         end
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   assign sb.store_ready_o = count != CAP || coal_match;
   assign sb.flush_valid_o = fv;
   assign sb.flush_addr_o = fv ? {waddr[head], 2'b00} : '0;
   assign sb.flush_data_o = fv ? data[head] : '0;
   assign sb.flush_be_o = fv ? be[head] : '0;
   assign sb.count_o = count;
   assign sb.full_o = count == CAP;
   assign sb.empty_o = !fv;
   assign sb.load_hit_o = sb.load_req_i && lookup == SB_HIT;
   assign sb.load_miss_o = sb.load_req_i && lookup == SB_MISS;
   assign sb.load_trouble_o = sb.load_req_i && lookup == SB_TROUBLE;
   assign sb.load_data_o = sb.load_req_i ? (fwd_data & ld_bm) >> memop_shift(sb.load_addr_i[1:0]) : '0;
endmodule

// File: tb/tb_segre_store_buffer_n.sv
// tb_segre_store_buffer_n: directed vector table plus hand sequences for full, wrap, same-cycle and reset cases
module tb_segre_store_buffer_n;
   import segre_store_buffer_n_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   segre_store_buffer_n_if #(.ADDR_SIZE(32), .WORD_SIZE(32), .NUM_ENTRIES(4)) sb ();
   segre_store_buffer_n #(.NUM_ENTRIES(4), .ADDR_SIZE(32), .WORD_SIZE(32), .COALESCE_EN(1'b1)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .sb(sb)
   );
   typedef struct {
      logic sv; logic [31:0] sa; logic [31:0] sd; memop_data_type_e st;
      logic lr; logic [31:0] la; memop_data_type_e lt; logic fr;
      logic [2:0] hmt; logic [31:0] ld; logic [2:0] cnt; logic sr; logic fv;
      logic [31:0] fa; logic [31:0] fd; logic [3:0] fbe;
   } vec_t;
   vec_t vt[22];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input memop_data_type_e st,
                        input logic lr, input logic [31:0] la, input memop_data_type_e lt, input logic fr);
      sb.store_valid_i = sv;
      sb.store_addr_i = sa;
      sb.store_data_i = sd;
      sb.store_type_i = st;
      sb.load_req_i = lr;
      sb.load_addr_i = la;
      sb.load_type_i = lt;
      sb.flush_ready_i = fr;
      #1;
   endtask
   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, BYTE, 1'b0, 32'h0, BYTE, 1'b0);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic store(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
      drive(1'b1, a, d, t, 1'b0, 32'h0, BYTE, 1'b0);
      tick();
   endtask
   task automatic pop_chk(input string name, input logic [31:0] a, input logic [31:0] d);
      drive(1'b0, 32'h0, 32'h0, BYTE, 1'b0, 32'h0, BYTE, 1'b1);
      chk({name, " flush_addr"}, sb.flush_addr_o, a);
      chk({name, " flush_data"}, sb.flush_data_o, d);
      tick();
   endtask
   initial begin
      //         sv sa        sd           st    lr la        lt    fr hmt     ld            cnt sr fv fa        fd            fbe
      vt[0]  = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        0, 1, 0, 'h0,    'h0,        'h0};
      vt[1]  = '{1, 'h1000, 'hDEADBEEF,  WORD, 1, 'h1000, WORD, 0, 3'b010, 'h0,        0, 1, 0, 'h0,    'h0,        'h0};
      vt[2]  = '{0, 'h0,    'h0,         BYTE, 1, 'h1000, WORD, 0, 3'b100, 'hDEADBEEF, 1, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[3]  = '{1, 'h2001, 'hAA,        BYTE, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        1, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[4]  = '{0, 'h0,    'h0,         BYTE, 1, 'h2000, HALF, 0, 3'b001, 'hAA00,     2, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[5]  = '{0, 'h0,    'h0,         BYTE, 1, 'h2001, BYTE, 0, 3'b100, 'hAA,       2, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[6]  = '{0, 'h0,    'h0,         BYTE, 1, 'h3000, WORD, 0, 3'b010, 'h0,        2, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[7]  = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        2, 1, 1, 'h1000, 'hDEADBEEF, 'hF};
      vt[8]  = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        1, 1, 1, 'h2000, 'hAA00,     'h2};
      vt[9]  = '{1, 'h4000, 'h11,        BYTE, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        0, 1, 0, 'h0,    'h0,        'h0};
      vt[10] = '{1, 'h4002, 'h22,        BYTE, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        1, 1, 1, 'h4000, 'h11,       'h1};
      vt[11] = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        1, 1, 1, 'h4000, 'h220011,   'h5};
      vt[12] = '{1, 'h5000, 'h1,         WORD, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        0, 1, 0, 'h0,    'h0,        'h0};
      vt[13] = '{1, 'h5004, 'h99,        WORD, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        1, 1, 1, 'h5000, 'h1,        'hF};
      vt[14] = '{1, 'h5000, 'h2,         WORD, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        2, 1, 1, 'h5000, 'h1,        'hF};
      vt[15] = '{0, 'h0,    'h0,         BYTE, 1, 'h5000, WORD, 0, 3'b100, 'h2,        3, 1, 1, 'h5000, 'h1,        'hF};
      vt[16] = '{0, 'h0,    'h0,         BYTE, 1, 'h5005, BYTE, 0, 3'b100, 'h0,        3, 1, 1, 'h5000, 'h1,        'hF};
      vt[17] = '{0, 'h0,    'h0,         BYTE, 1, 'h5000, HALF, 0, 3'b100, 'h2,        3, 1, 1, 'h5000, 'h1,        'hF};
      vt[18] = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        3, 1, 1, 'h5000, 'h1,        'hF};
      vt[19] = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        2, 1, 1, 'h5004, 'h99,       'hF};
      vt[20] = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 1, 3'b000, 'h0,        1, 1, 1, 'h5000, 'h2,        'hF};
      vt[21] = '{0, 'h0,    'h0,         BYTE, 0, 'h0,    BYTE, 0, 3'b000, 'h0,        0, 1, 0, 'h0,    'h0,        'h0};
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset empty", sb.empty_o, 1'b1);
      chk("reset full", sb.full_o, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 22; i++) begin
         drive(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].st, vt[i].lr, vt[i].la, vt[i].lt, vt[i].fr);
         chk($sformatf("v%0d hit/miss/trouble", i), {sb.load_hit_o, sb.load_miss_o, sb.load_trouble_o}, vt[i].hmt);
         chk($sformatf("v%0d load_data", i), sb.load_data_o, vt[i].ld);
         chk($sformatf("v%0d count", i), sb.count_o, vt[i].cnt);
         chk($sformatf("v%0d store_ready", i), sb.store_ready_o, vt[i].sr);
         chk($sformatf("v%0d flush_valid", i), sb.flush_valid_o, vt[i].fv);
         chk($sformatf("v%0d empty", i), sb.empty_o, !vt[i].fv);
         chk($sformatf("v%0d flush_addr", i), sb.flush_addr_o, vt[i].fa);
         chk($sformatf("v%0d flush_data", i), sb.flush_data_o, vt[i].fd);
         chk($sformatf("v%0d flush_be", i), sb.flush_be_o, vt[i].fbe);
         tick();
      end
      // fill to full, then probe store_ready against the youngest and a new word
      for (int i = 0; i < 4; i++) store(32'h7000 + 32'(4*i), 32'(4*i), WORD);
      drive(1'b0, 32'h8000, 32'h0, WORD, 1'b0, 32'h0, BYTE, 1'b0);
      chk("fill full", sb.full_o, 1'b1);
      chk("fill count", sb.count_o, 3'd4);
      chk("fill ready new word", sb.store_ready_o, 1'b0);
      drive(1'b0, 32'h700E, 32'h0, BYTE, 1'b0, 32'h0, BYTE, 1'b0);
      chk("fill ready youngest word", sb.store_ready_o, 1'b1);
      store(32'h700E, 32'h55, BYTE);
      chk("full coalesce count", sb.count_o, 3'd4);
      drive(1'b1, 32'h9000, 32'h9, WORD, 1'b0, 32'h0, BYTE, 1'b1);
      chk("full pop refuses store", sb.store_ready_o, 1'b0);
      chk("full pop head", sb.flush_addr_o, 32'h7000);
      tick();
      idle();
      chk("after refused store count", sb.count_o, 3'd3);
      pop_chk("pop1", 32'h7004, 32'h4);
      pop_chk("pop2", 32'h7008, 32'h8);
      pop_chk("pop3", 32'h700C, 32'h0055000C);
      idle();
      chk("drained empty", sb.empty_o, 1'b1);
      // refill across the index wrap
      store(32'hA000, 32'h1, WORD);
      store(32'hA004, 32'h2, WORD);
      store(32'hA008, 32'h3, WORD);
      pop_chk("wrap1", 32'hA000, 32'h1);
      pop_chk("wrap2", 32'hA004, 32'h2);
      pop_chk("wrap3", 32'hA008, 32'h3);
      // same-cycle store, pop and load on a one-entry buffer
      store(32'h6000, 32'h66, WORD);
      drive(1'b1, 32'h6000, 32'h77, WORD, 1'b1, 32'h6000, WORD, 1'b1);
      chk("same-cycle load hit", sb.load_hit_o, 1'b1);
      chk("same-cycle load data", sb.load_data_o, 32'h66);
      tick();
      idle();
      chk("same-cycle count", sb.count_o, 3'd1);
      chk("same-cycle new head addr", sb.flush_addr_o, 32'h6000);
      chk("same-cycle new head data", sb.flush_data_o, 32'h77);
      // reset mid-operation discards entries
      store(32'hB000, 32'hB, WORD);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid reset count", sb.count_o, 3'd0);
      chk("mid reset flush_valid", sb.flush_valid_o, 1'b0);
      chk("mid reset flush_data", sb.flush_data_o, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/segre_store_buffer_n.md
Name: segre_store_buffer_n

Overview:
- Parametrised successor to the core's fixed two-entry store buffer: an N-entry circular FIFO of word-aligned, byte-enabled stores sitting between the TL stage and the data cache.
- Adds byte-granular store-to-load forwarding, optional coalescing into the youngest entry, and a valid/ready drain port towards the dcache/MMU.
- Loads are checked combinationally in the same cycle; drains retire the oldest entry in order.

Parameters:
- NUM_ENTRIES, 4, buffer depth; power of two, >= 2.
- ADDR_SIZE, 32, address width.
- WORD_SIZE, 32, data width; byte lanes = WORD_SIZE/8.
- COALESCE_EN, 1, allow a store to merge into the youngest entry when the word address matches.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- store_valid_i  in  1  store request.
- store_ready_o  out  1  store accepted when valid&&ready.
- store_addr_i  in  ADDR_SIZE  byte address.
- store_data_i  in  WORD_SIZE  right-aligned store data.
- store_type_i  in  2  memop_data_type_e (BYTE/HALF/WORD).
- load_req_i  in  1  load lookup.
- load_addr_i  in  ADDR_SIZE  byte address.
- load_type_i  in  2  memop_data_type_e.
- load_hit_o  out  1  all load bytes forwarded.
- load_miss_o  out  1  no load byte present.
- load_trouble_o  out  1  partial overlap; the load must wait for a drain.
- load_data_o  out  WORD_SIZE  forwarded bytes, right-aligned, zero-extended.
- flush_valid_o  out  1  head entry available.
- flush_ready_i  in  1  consumer takes the head.
- flush_addr_o  out  ADDR_SIZE  head word address, low 2 bits zero.
- flush_data_o  out  WORD_SIZE  head word, lane-aligned.
- flush_be_o  out  WORD_SIZE/8  head byte enables.
- count_o  out  $clog2(NUM_ENTRIES)+1  occupancy.
- full_o, empty_o  out  1  status.

Behaviour:
- Reset: head=tail=count=0 and all valid bits cleared. Outputs: flush_valid_o=0, full_o=0, empty_o=1, store_ready_o=1, load_* = 0, flush_* data = 0.
- Entry format: {word_addr, data[WORD_SIZE], be[WORD_SIZE/8]}.
- Lane placement: shift = addr[1:0]*8.
  - BYTE: be = 1<<addr[1:0].
  - HALF: be = 2'b11<<addr[1:0].
  - WORD: be = all ones.
  - Misaligned accesses are trapped upstream and never presented. Lanes beyond the word are dropped.
- Store acceptance, on a rising edge with store_valid_i && store_ready_o:
  - Coalesce: applies if COALESCE_EN, count>0, the youngest entry's word_addr matches, and NOT (youngest == head && flush_valid_o && flush_ready_i). The enabled bytes overwrite the entry, its be is ORed, and count is unchanged.
  - Otherwise: write at tail, tail++ (wraps mod NUM_ENTRIES), count++.
- store_ready_o = !full_o || coalesce_possible. It depends only on registered state plus the store inputs, never on flush_ready_i.
- Drain: flush_valid_o = !empty_o. On flush_valid_o && flush_ready_i: head++ (wrap), count--. The flush_* outputs hold stable while valid && !ready.
- Enqueue and dequeue in the same cycle: count unchanged. When full, that cycle's store is still refused unless it coalesces.
- Load lookup is combinational and uses registered state only. A store in the same cycle is not visible; a pop in the same cycle does not hide the entry.
  - Required mask rm comes from load_addr_i/load_type_i.
  - Scan from youngest to oldest. Per byte lane, take the youngest entry with a matching word_addr and that be bit set.
  - hit = all rm lanes covered. miss = no rm lane covered. trouble = otherwise.
  - load_data_o = covered lanes shifted down by addr[1:0]*8. Lanes outside rm are zero.
  - With load_req_i=0: hit, miss and trouble are all 0; load_data_o = 0.
- Exactly one of hit/miss/trouble is high when load_req_i=1.
- Reset mid-operation discards all entries with no drain.

Decomposition:
- Add to segre_pkg:
  - SB_NUM_ENTRIES (replaces STORE_BUFFER_NUM_ELEMS).
  - sb_entry_t packed struct {word_addr, data, be}.
  - sb_lookup_e {SB_HIT, SB_MISS, SB_TROUBLE}.
  - Functions memop_be() and memop_shift().
- One sub-module: segre_sb_forward, the combinational youngest-first per-lane priority selector over the entry array, returning the data and the covered mask.

Test Plan:
- Reset, then store WORD 0x1000=0xDEADBEEF, then load WORD 0x1000 -> hit=1, load_data_o=0xDEADBEEF, count_o=1.
- Store BYTE 0x2001=0xAA, then load HALF 0x2000 -> trouble=1. Then load BYTE 0x2001 -> hit, data=0x000000AA. Then load WORD 0x3000 -> miss.
- COALESCE_EN=1: store BYTE 0x4000=0x11, then BYTE 0x4002=0x22 -> count_o=1. Drain -> flush_addr=0x4000, flush_be=4'b0101, flush_data=0x00220011.
- Fill 4 stores to distinct words with flush_ready_i=0 -> full_o=1, store_ready_o=0 for a new word, store_ready_o=1 for the youngest's word. Pop all with flush_ready_i=1 -> FIFO order, and the wrap-around refill works.
- Two stores to 0x5000 (WORD 0x1, then a different word, then WORD 0x2) -> a load returns 0x2 (youngest wins).
- Simultaneous store, pop and load on a one-entry buffer whose head is 0x6000 -> the load sees the head (hit), the store allocates a new entry rather than coalescing, and count stays 1.
